// File: rtl/register_bank.sv
// Byte-addressed control/status register bank. It has read-only ID registers, a scratch
// register, NUM_OUT output registers, and NUM_KEYS debounced key inputs with a maskable event interrupt.
module register_bank #(
    parameter logic [7:0] DEV_TYPE        = 8'hA5,
    parameter logic [7:0] VERSION         = 8'h02,
    parameter int         NUM_OUT         = 4,
    parameter int         OUT_W           = 4,
    parameter int         NUM_KEYS        = 1,
    parameter int         DEBOUNCE_CYCLES = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [7:0]               addr,
    input  logic [7:0]               dataIn,
    input  logic                     writeEn,
    output logic [7:0]               dataOut,
    output logic [NUM_OUT*OUT_W-1:0] outRegs,
    input  logic [NUM_KEYS-1:0]      keys,
    output logic                     irq
);

    localparam int         CW         = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [7:0] A_DEV      = 8'h00;
    localparam logic [7:0] A_VER      = 8'h01;
    localparam logic [7:0] A_KSTATE   = 8'h02;
    localparam logic [7:0] A_KEVENT   = 8'h03;
    localparam logic [7:0] A_MASK     = 8'h04;
    localparam logic [7:0] A_SCRATCH  = 8'h05;
    localparam int         OUT_BASE   = 16;

    logic [NUM_KEYS-1:0] sync1_q, sync2_q;
    logic [NUM_KEYS-1:0] deb_q, deb_d;
    logic [CW-1:0]       cnt_q [NUM_KEYS];
    logic [CW-1:0]       cnt_d [NUM_KEYS];
    logic [NUM_KEYS-1:0] event_q, event_d, event_clr;
    logic [NUM_KEYS-1:0] mask_q, mask_d;
    logic [7:0]          scratch_q, scratch_d;
    logic [OUT_W-1:0]    out_q [NUM_OUT];
    logic [OUT_W-1:0]    out_d [NUM_OUT];
    logic [7:0]          data_out_q, rd_data;

    // Debounce: a key toggles only after its synchronised level has differed
    // from the debounced state for DEBOUNCE_CYCLES consecutive cycles.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
        deb_d = deb_q;
        for (int k = 0; k < NUM_KEYS; k++) begin
            cnt_d[k] = '0;
            if (sync2_q[k] != deb_q[k]) begin
                if (cnt_q[k] == CW'(DEBOUNCE_CYCLES - 1)) begin
                    deb_d[k] = ~deb_q[k];
                end else begin
                    cnt_d[k] = cnt_q[k] + CW'(1);
                end
            end
        end
    end

    always_comb begin
        mask_d    = mask_q;
        scratch_d = scratch_q;
        event_clr = '0;
        out_d     = out_q;
        if (writeEn) begin
            case (addr)
                A_KEVENT:  event_clr = dataIn[NUM_KEYS-1:0];
                A_MASK:    mask_d    = dataIn[NUM_KEYS-1:0];
                A_SCRATCH: scratch_d = dataIn;
                default: begin
                    for (int i = 0; i < NUM_OUT; i++) begin
                        if (addr == 8'(OUT_BASE + i)) out_d[i] = dataIn[OUT_W-1:0];
                    end
                end
            endcase
        end
        // A rising edge in the same cycle as a W1C clear wins.
        event_d = (event_q & ~event_clr) | (deb_d & ~deb_q);
    end

    // Reads sample the pre-write register contents.
    always_comb begin
        rd_data = '0;
        case (addr)
            A_DEV:     rd_data = DEV_TYPE;
            A_VER:     rd_data = VERSION;
            A_KSTATE:  rd_data[NUM_KEYS-1:0] = deb_q;
            A_KEVENT:  rd_data[NUM_KEYS-1:0] = event_q;
            A_MASK:    rd_data[NUM_KEYS-1:0] = mask_q;
            A_SCRATCH: rd_data = scratch_q;
            default: begin
                for (int i = 0; i < NUM_OUT; i++) begin
                    if (addr == 8'(OUT_BASE + i)) rd_data[OUT_W-1:0] = out_q[i];
                end
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples the values from before the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            deb_q      <= '0;
            event_q    <= '0;
            mask_q     <= '0;
            scratch_q  <= '0;
            data_out_q <= '0;
            for (int k = 0; k < NUM_KEYS; k++) cnt_q[k] <= '0;
            // NOTE: the output array is a handful of flops driving pins, not a RAM, so resetting it is cheap and keeps the pins defined.
            for (int i = 0; i < NUM_OUT; i++) out_q[i] <= '0;
        end else begin
            sync1_q    <= keys;
            sync2_q    <= sync1_q;
            deb_q      <= deb_d;
            event_q    <= event_d;
            mask_q     <= mask_d;
            scratch_q  <= scratch_d;
            data_out_q <= rd_data;
            for (int k = 0; k < NUM_KEYS; k++) cnt_q[k] <= cnt_d[k];
            for (int i = 0; i < NUM_OUT; i++) out_q[i] <= out_d[i];
        end
    end

    for (genvar i = 0; i < NUM_OUT; i++) begin : g_out
        assign outRegs[i*OUT_W +: OUT_W] = out_q[i];
    end

    assign dataOut = data_out_q;
    assign irq     = |(event_q & mask_q);

endmodule
